redmule_tcdm_arb: RTL and testbench
===================================

REDMULE_TCDM_ARB -- requirements
Module: redmule_tcdm_arb

Interface
REQ-001 SHALL have parameter MP, default 4, the number of 32-bit memory banks (power of 2, >=2).
REQ-002 SHALL have parameter IW, default 8, the wide-port request/response ID width.
REQ-003 SHALL have parameter DEPTH, default 4, the maximum number of outstanding transactions (power of 2).
REQ-004 SHALL have parameter MAX_STALL, default 8, the narrow-port starvation threshold in cycles.
REQ-005 SHALL have port clk_i, input, 1 bit: clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have wide (accelerator) request ports: w_req_i 1, w_gnt_o 1, w_add_i 32, w_wen_i 1 (1 = read), w_be_i MP*4, w_data_i MP*32, w_id_i IW.
REQ-008 SHALL have wide response ports: w_r_valid_o 1, w_r_data_o MP*32, w_r_id_o IW.
REQ-009 SHALL have narrow (core) request ports: n_req_i 1, n_gnt_o 1, n_add_i 32, n_wen_i 1, n_be_i 4, n_data_i 32.
REQ-010 SHALL have narrow response ports: n_r_valid_o 1, n_r_data_o 32.
REQ-011 SHALL have bank-side ports, each MP-wide arrays: b_req_o, b_gnt_i, b_add_o[32], b_wen_o, b_be_o[4], b_data_o[32], b_r_valid_i, b_r_data_i[32].

Function
REQ-012 A wide request SHALL drive all MP banks; bank k SHALL receive address w_add_i + 4k and data/be slice k, with slice 0 in the LSBs.
REQ-013 A narrow request SHALL drive only bank s = n_add_i[2 +: log2(MP)], with the address passed unchanged.
REQ-014 A wide grant (w_gnt_o = 1) SHALL occur only when every b_gnt_i is 1 in the same cycle; otherwise b_req_o SHALL be held and no bank access is counted.
REQ-015 A narrow grant SHALL occur when b_gnt_i[s] = 1 while the narrow port is the selected owner.
REQ-016 Arbitration, evaluated each cycle: by default wide has priority over narrow; when stall_cnt == MAX_STALL, narrow SHALL have priority for exactly one grant.
REQ-017 At most one requester SHALL drive b_req_o per cycle; the loser's gnt SHALL be 0.
REQ-018 stall_cnt SHALL increment by 1 per cycle while n_req_i = 1 and narrow is not granted, saturating at MAX_STALL; it SHALL clear to 0 on a narrow grant or when n_req_i = 0.
REQ-019 An outstanding FIFO of DEPTH entries SHALL record, per grant, {owner, bank s, id}; it SHALL push on grant.
REQ-020 When the FIFO is full, no b_req_o SHALL be asserted and both gnt outputs SHALL be 0; a pop and a push in the same cycle while full SHALL be allowed.
REQ-021 Each granted access (read or write) SHALL produce exactly one response; responses SHALL be returned in grant order.
REQ-022 When the head entry is wide, w_r_valid_o SHALL equal the AND of all b_r_valid_i, with w_r_data_o equal to the concatenated bank data and w_r_id_o equal to the head id.
REQ-023 When the head entry is narrow, n_r_valid_o SHALL equal b_r_valid_i[s] and n_r_data_o SHALL equal b_r_data_i[s].
REQ-024 The FIFO SHALL pop in the same cycle that a response valid is output; response outputs SHALL be combinational from the bank inputs and the FIFO head.
REQ-025 If b_r_valid_i arrives while the FIFO is empty, it SHALL be ignored and an assertion SHALL flag it.
REQ-026 Request path latency SHALL be 0 cycles (combinational request-to-bank); added response latency SHALL be 0.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-028 On rst_ni = 0, the FIFO SHALL be emptied, stall_cnt SHALL be 0, and all gnt, r_valid and b_req_o outputs SHALL be 0, immediately (asynchronously).
REQ-029 A reset mid-transaction SHALL drop all outstanding entries; no response SHALL be emitted for them after reset release.

Structure
REQ-030 The owner enum (OWNER_WIDE, OWNER_NARROW) and the FIFO entry struct SHALL be placed in redmule_pkg.
REQ-031 The outstanding FIFO SHALL be a single sub-module, redmule_tcdm_arb_fifo.

Verification
REQ-032 Wide-only traffic: wide read at 0x1C010000 with MP=4 -> banks receive addresses 0x..000/004/008/00C; response one cycle later; w_r_id_o equals the request id.
REQ-033 Both requesters held continuously with all banks granting -> exactly one narrow grant every 9 cycles (8 wide grants, then 1 narrow grant).
REQ-034 Bank 2 holds gnt = 0 for 3 cycles during a wide request -> w_gnt_o stays 0 for those 3 cycles and no FIFO push occurs.
REQ-035 Banks delay responses so that 4 grants are outstanding -> the 5th request is not granted until a response pops; responses come back in order (wide, narrow, wide, narrow).
REQ-036 Narrow write to address 0x1C010008 -> only bank 2 has b_req_o = 1; n_r_valid_o follows b_r_valid_i[2].
REQ-037 Assert rst_ni low with 3 transactions outstanding -> outputs are 0 immediately, and no stale r_valid appears after reset release.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE TCDM arbiter.
// Owner tag and outstanding-transaction record kept by the response FIFO.
package redmule_pkg;

    // Fixed-width fields so the record does not depend on arbiter parameters.
    localparam int unsigned BANK_SEL_W = 8;
    localparam int unsigned ID_MAX_W   = 32;

    typedef enum logic {
        OWNER_WIDE   = 1'b0,
        OWNER_NARROW = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e                owner;
        logic [BANK_SEL_W-1:0] bank;
        logic [ID_MAX_W-1:0]   id;
    } arb_entry_t;

endpackage

// File: rtl/redmule_tcdm_arb_if.sv
// Bus bundle for the TCDM arbiter: wide port, narrow port and MP banks.
// slave = arbiter view, master = requester/bank environment view.
interface redmule_tcdm_arb_if #(
    parameter int unsigned MP = 4,
    parameter int unsigned IW = 8
);
    logic                 w_req_i;
    logic                 w_gnt_o;
    logic [31:0]          w_add_i;
    logic                 w_wen_i;
    logic [MP*4-1:0]      w_be_i;
    logic [MP*32-1:0]     w_data_i;
    logic [IW-1:0]        w_id_i;
    logic                 w_r_valid_o;
    logic [MP*32-1:0]     w_r_data_o;
    logic [IW-1:0]        w_r_id_o;

    logic                 n_req_i;
    logic                 n_gnt_o;
    logic [31:0]          n_add_i;
    logic                 n_wen_i;
    logic [3:0]           n_be_i;
    logic [31:0]          n_data_i;
    logic                 n_r_valid_o;
    logic [31:0]          n_r_data_o;

    logic [MP-1:0]        b_req_o;
    logic [MP-1:0]        b_gnt_i;
    logic [MP-1:0][31:0]  b_add_o;
    logic [MP-1:0]        b_wen_o;
    logic [MP-1:0][3:0]   b_be_o;
    logic [MP-1:0][31:0]  b_data_o;
    logic [MP-1:0]        b_r_valid_i;
    logic [MP-1:0][31:0]  b_r_data_i;

    modport slave (
        input  w_req_i, w_add_i, w_wen_i, w_be_i, w_data_i, w_id_i,
        output w_gnt_o, w_r_valid_o, w_r_data_o, w_r_id_o,
        input  n_req_i, n_add_i, n_wen_i, n_be_i, n_data_i,
        output n_gnt_o, n_r_valid_o, n_r_data_o,
        output b_req_o, b_add_o, b_wen_o, b_be_o, b_data_o,
        input  b_gnt_i, b_r_valid_i, b_r_data_i
    );

    modport master (
        output w_req_i, w_add_i, w_wen_i, w_be_i, w_data_i, w_id_i,
        input  w_gnt_o, w_r_valid_o, w_r_data_o, w_r_id_o,
        output n_req_i, n_add_i, n_wen_i, n_be_i, n_data_i,
        input  n_gnt_o, n_r_valid_o, n_r_data_o,
        input  b_req_o, b_add_o, b_wen_o, b_be_o, b_data_o,
        output b_gnt_i, b_r_valid_i, b_r_data_i
    );

endinterface

// File: rtl/redmule_tcdm_arb_fifo.sv
// Outstanding-transaction FIFO: one record per grant, popped per response.
// Ports: clk_i/rst_ni, push_i/data_i, pop_i/data_o (head), full_o, empty_o.
module redmule_tcdm_arb_fifo
    import redmule_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  arb_entry_t data_i,
    input  logic       pop_i,
    output arb_entry_t data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    arb_entry_t        mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       cnt_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves this cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/redmule_tcdm_arb.sv
// TCDM arbiter sharing MP banks between a wide accelerator port and a core.
// Ports: clk_i, rst_ni, bus (slave view of redmule_tcdm_arb_if).
module redmule_tcdm_arb
    import redmule_pkg::*;
#(
    parameter int unsigned MP        = 4,
    parameter int unsigned IW        = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_STALL = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    redmule_tcdm_arb_if.slave   bus
);

    localparam int unsigned SW = $clog2(MP);
    localparam int unsigned CW = $clog2(MAX_STALL + 1);

    logic [SW-1:0] n_sel;
    logic [SW-1:0] head_sel;
    logic [CW-1:0] stall_cnt_q;
    logic          narrow_prio;
    logic          arb_en;
    logic          own_w;
    logic          own_n;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    arb_entry_t    push_entry;
    arb_entry_t    head;

    assign n_sel       = bus.n_add_i[2 +: SW];
    assign narrow_prio = (stall_cnt_q == CW'(MAX_STALL));

    // No owner at all while in reset or when nothing can be recorded.
    assign arb_en = rst_ni && (!fifo_full || pop);

    always_comb begin
        own_w = 1'b0;
        own_n = 1'b0;
        if (arb_en) begin
            if (bus.n_req_i && narrow_prio) begin
                own_n = 1'b1;
            end else if (bus.w_req_i) begin
                own_w = 1'b1;
            end else if (bus.n_req_i) begin
                own_n = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < MP; k++) begin : g_bank
        assign bus.b_req_o[k]  = own_w | (own_n & (n_sel == SW'(k)));
        assign bus.b_add_o[k]  = own_n ? bus.n_add_i
                                       : bus.w_add_i + (32'(k) << 2);
        assign bus.b_wen_o[k]  = own_n ? bus.n_wen_i : bus.w_wen_i;
        assign bus.b_be_o[k]   = own_n ? bus.n_be_i
                                       : bus.w_be_i[4*k +: 4];
        assign bus.b_data_o[k] = own_n ? bus.n_data_i
                                       : bus.w_data_i[32*k +: 32];
    end

    // Wide access is all-or-nothing across the banks.
    assign bus.w_gnt_o = own_w & (&bus.b_gnt_i);
    assign bus.n_gnt_o = own_n & bus.b_gnt_i[n_sel];
    assign push        = bus.w_gnt_o | bus.n_gnt_o;

    always_comb begin
        push_entry       = '0;
        push_entry.owner = own_n ? OWNER_NARROW : OWNER_WIDE;
        push_entry.bank  = BANK_SEL_W'(n_sel);
        push_entry.id    = own_n ? '0 : ID_MAX_W'(bus.w_id_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (!bus.n_req_i || bus.n_gnt_o) begin
            stall_cnt_q <= '0;
        end else if (!narrow_prio) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    redmule_tcdm_arb_fifo #(
        .DEPTH (DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_sel = head.bank[SW-1:0];

    assign bus.w_r_valid_o = !fifo_empty && (head.owner == OWNER_WIDE)
                             && (&bus.b_r_valid_i);
    assign bus.w_r_data_o  = bus.b_r_data_i;
    assign bus.w_r_id_o    = head.id[IW-1:0];

    assign bus.n_r_valid_o = !fifo_empty && (head.owner == OWNER_NARROW)
                             && bus.b_r_valid_i[head_sel];
    assign bus.n_r_data_o  = bus.b_r_data_i[head_sel];

    assign pop = bus.w_r_valid_o | bus.n_r_valid_o;

`ifndef SYNTHESIS
    a_no_orphan_rsp : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(fifo_empty && |bus.b_r_valid_i)
    ) else $error("bank response with nothing outstanding");

    a_head_sane : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !fifo_empty |-> ((head.bank < BANK_SEL_W'(MP))
                         && ((head.id >> IW) == '0))
    ) else $error("corrupt outstanding record");
`endif

endmodule

// File: tb/tb_redmule_tcdm_arb.sv
// Directed self-checking bench for redmule_tcdm_arb (MP=4, IW=8, DEPTH=4).
// Drives both requesters and the banks by hand and checks hand-derived values.
module tb_redmule_tcdm_arb;

    localparam int MP        = 4;
    localparam int IW        = 8;
    localparam int DEPTH     = 4;
    localparam int MAX_STALL = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    redmule_tcdm_arb_if #(.MP(MP), .IW(IW)) bus ();

    redmule_tcdm_arb #(
        .MP        (MP),
        .IW        (IW),
        .DEPTH     (DEPTH),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.w_req_i     = 1'b0;
        bus.w_add_i     = '0;
        bus.w_wen_i     = 1'b0;
        bus.w_be_i      = '1;
        bus.w_data_i    = '0;
        bus.w_id_i      = '0;
        bus.n_req_i     = 1'b0;
        bus.n_add_i     = '0;
        bus.n_wen_i     = 1'b0;
        bus.n_be_i      = '1;
        bus.n_data_i    = '0;
        bus.b_gnt_i     = '1;
        bus.b_r_valid_i = '0;
        bus.b_r_data_i  = '0;

        // Reset state: requests are ignored while in reset.
        bus.w_req_i = 1'b1;
        #2;
        check("rst_w_gnt", bus.w_gnt_o, 0);
        check("rst_b_req", bus.b_req_o, 0);
        check("rst_w_rvalid", bus.w_r_valid_o, 0);
        check("rst_n_rvalid", bus.n_r_valid_o, 0);
        bus.w_req_i = 1'b0;
        #10 rst_n = 1'b1;
        step();

        // Wide read, address fan-out and one-cycle response.
        bus.w_req_i  = 1'b1;
        bus.w_add_i  = 32'h1C01_0000;
        bus.w_wen_i  = 1'b1;
        bus.w_id_i   = 8'h5A;
        bus.w_data_i = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        #1;
        check("wr_b_req", bus.b_req_o, 4'hF);
        check("wr_add0", bus.b_add_o[0], 32'h1C01_0000);
        check("wr_add1", bus.b_add_o[1], 32'h1C01_0004);
        check("wr_add2", bus.b_add_o[2], 32'h1C01_0008);
        check("wr_add3", bus.b_add_o[3], 32'h1C01_000C);
        check("wr_data3", bus.b_data_o[3], 32'h4444_4444);
        check("wr_gnt", bus.w_gnt_o, 1);
        step();
        bus.w_req_i     = 1'b0;
        bus.b_r_valid_i = 4'hF;
        for (int k = 0; k < MP; k++) begin
            bus.b_r_data_i[k] = 32'hA000_0000 + 32'(k);
        end
        #1;
        check("wr_rvalid", bus.w_r_valid_o, 1);
        check("wr_rdata", bus.w_r_data_o,
              128'hA000_0003_A000_0002_A000_0001_A000_0000);
        check("wr_rid", bus.w_r_id_o, 8'h5A);
        check("wr_n_rvalid", bus.n_r_valid_o, 0);
        step();
        bus.b_r_valid_i = '0;

        // Narrow write to bank 2 only.
        bus.n_req_i  = 1'b1;
        bus.n_add_i  = 32'h1C01_0008;
        bus.n_wen_i  = 1'b0;
        bus.n_data_i = 32'hCAFE_F00D;
        #1;
        check("nw_b_req", bus.b_req_o, 4'b0100);
        check("nw_add2", bus.b_add_o[2], 32'h1C01_0008);
        check("nw_data2", bus.b_data_o[2], 32'hCAFE_F00D);
        check("nw_wen2", bus.b_wen_o[2], 0);
        check("nw_gnt", bus.n_gnt_o, 1);
        check("nw_w_gnt", bus.w_gnt_o, 0);
        step();
        bus.n_req_i = 1'b0;
        #1;
        check("nw_wait", bus.n_r_valid_o, 0);
        step();
        bus.b_r_valid_i   = 4'b0100;
        bus.b_r_data_i[2] = 32'h1234_5678;
        #1;
        check("nw_rvalid", bus.n_r_valid_o, 1);
        check("nw_rdata", bus.n_r_data_o, 32'h1234_5678);
        step();
        bus.b_r_valid_i = '0;

        // Bank 2 withholds its grant for three cycles.
        bus.w_req_i = 1'b1;
        bus.w_id_i  = 8'h33;
        bus.b_gnt_i = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_w_gnt", bus.w_gnt_o, 0);
            check("st_b_req", bus.b_req_o, 4'hF);
            step();
        end
        bus.b_gnt_i = 4'hF;
        #1;
        check("st_gnt", bus.w_gnt_o, 1);
        step();
        bus.w_req_i     = 1'b0;
        bus.b_r_valid_i = 4'hF;
        #1;
        check("st_rvalid", bus.w_r_valid_o, 1);
        check("st_rid", bus.w_r_id_o, 8'h33);
        step();
        bus.b_r_valid_i = '0;

        // Fill all four slots: wide, narrow, wide, narrow.
        bus.w_req_i = 1'b1;
        bus.w_id_i  = 8'h01;
        step();
        bus.w_req_i = 1'b0;
        bus.n_req_i = 1'b1;
        bus.n_add_i = 32'h1C01_0004;
        bus.n_wen_i = 1'b1;
        step();
        bus.n_req_i = 1'b0;
        bus.w_req_i = 1'b1;
        bus.w_id_i  = 8'h03;
        step();
        bus.w_req_i = 1'b0;
        bus.n_req_i = 1'b1;
        bus.n_add_i = 32'h1C01_000C;
        step();
        bus.n_req_i = 1'b0;
        bus.w_req_i = 1'b1;
        bus.w_id_i  = 8'h05;
        #1;
        check("full_w_gnt", bus.w_gnt_o, 0);
        check("full_b_req", bus.b_req_o, 0);
        step();
        check("full_w_gnt2", bus.w_gnt_o, 0);
        bus.b_r_valid_i = 4'hF;
        #1;
        check("full_r0_valid", bus.w_r_valid_o, 1);
        check("full_r0_id", bus.w_r_id_o, 8'h01);
        check("full_popgnt", bus.w_gnt_o, 1);
        step();
        bus.w_req_i       = 1'b0;
        bus.b_r_valid_i   = 4'b0010;
        bus.b_r_data_i[1] = 32'h0000_00B1;
        #1;
        check("ord_r1_valid", bus.n_r_valid_o, 1);
        check("ord_r1_data", bus.n_r_data_o, 32'h0000_00B1);
        check("ord_r1_wide", bus.w_r_valid_o, 0);
        step();
        bus.b_r_valid_i = 4'hF;
        #1;
        check("ord_r2_valid", bus.w_r_valid_o, 1);
        check("ord_r2_id", bus.w_r_id_o, 8'h03);
        step();
        bus.b_r_valid_i   = 4'b1000;
        bus.b_r_data_i[3] = 32'h0000_00B3;
        #1;
        check("ord_r3_valid", bus.n_r_valid_o, 1);
        check("ord_r3_data", bus.n_r_data_o, 32'h0000_00B3);
        step();
        bus.b_r_valid_i = 4'hF;
        #1;
        check("ord_r4_valid", bus.w_r_valid_o, 1);
        check("ord_r4_id", bus.w_r_id_o, 8'h05);
        step();
        bus.b_r_valid_i = '0;

        // Both requesters held: eight wide grants then one narrow.
        bus.w_req_i = 1'b1;
        bus.w_id_i  = 8'h20;
        bus.n_req_i = 1'b1;
        bus.n_add_i = 32'h1C01_0000;
        for (int i = 0; i < 18; i++) begin
            if (i > 0) begin
                bus.b_r_valid_i = 4'hF;
            end
            #1;
            check("fair_n_gnt", bus.n_gnt_o, (i % 9) == 8);
            check("fair_w_gnt", bus.w_gnt_o, (i % 9) != 8);
            if (i > 0) begin
                check("fair_n_rvalid", bus.n_r_valid_o, ((i - 1) % 9) == 8);
            end
            step();
        end
        bus.w_req_i     = 1'b0;
        bus.n_req_i     = 1'b0;
        bus.b_r_valid_i = 4'hF;
        #1;
        check("fair_last_rsp", bus.n_r_valid_o, 1);
        step();
        bus.b_r_valid_i = '0;

        // Reset with three transactions outstanding.
        bus.w_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.w_id_i = 8'(7 + i);
            step();
        end
        #1;
        rst_n           = 1'b0;
        bus.b_r_valid_i = 4'hF;
        #1;
        check("mrst_w_gnt", bus.w_gnt_o, 0);
        check("mrst_b_req", bus.b_req_o, 0);
        check("mrst_w_rvalid", bus.w_r_valid_o, 0);
        check("mrst_n_gnt", bus.n_gnt_o, 0);
        bus.b_r_valid_i = '0;
        bus.w_req_i     = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.n_req_i = 1'b1;
        bus.n_add_i = 32'h1C01_0000;
        bus.n_wen_i = 1'b1;
        #1;
        check("post_n_gnt", bus.n_gnt_o, 1);
        check("post_b_req", bus.b_req_o, 4'b0001);
        step();
        bus.n_req_i       = 1'b0;
        bus.b_r_valid_i   = 4'b0001;
        bus.b_r_data_i[0] = 32'h0000_00C0;
        #1;
        check("post_n_rvalid", bus.n_r_valid_o, 1);
        check("post_n_rdata", bus.n_r_data_o, 32'h0000_00C0);
        check("post_w_rvalid", bus.w_r_valid_o, 0);
        step();
        bus.b_r_valid_i = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
